// File: rtl/systolic_mul_4x4.sv
// rtl/systolic_mul_4x4.sv - 4x4 output-stationary systolic matrix multiplier (optional SYSTOLIC_START_EN adds start_i)

module systolic_mul_4x4_pe #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q,
    output logic [DATA_W-1:0] acc_q
);

    // Multiply-accumulate and forward the operands one hop right/down.
    // The product is truncated to DATA_W and the sum wraps modulo 2^DATA_W.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (enable) begin
            acc_q <= acc_q + a_in * b_in;
            a_q   <= a_in;
            b_q   <= b_in;
        end
    end

endmodule

module systolic_mul_4x4 #(
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef SYSTOLIC_START_EN
    input  logic                 start_i,
`endif
    input  logic [DATA_W-1:0]    left_i_0,
    input  logic [DATA_W-1:0]    left_i_4,
    input  logic [DATA_W-1:0]    left_i_8,
    input  logic [DATA_W-1:0]    left_i_12,
    input  logic [DATA_W-1:0]    up_i_0,
    input  logic [DATA_W-1:0]    up_i_1,
    input  logic [DATA_W-1:0]    up_i_2,
    input  logic [DATA_W-1:0]    up_i_3,
    output logic [16*DATA_W-1:0] c_o,
    output logic                 done
);

    localparam int N = 4;
    // Edges 0..3N-3 carry operands; done lands on the edge the counter reaches 3N-2.
    localparam logic [3:0] LAST_COUNT = 4'(3 * N - 3);

    logic [DATA_W-1:0] left_edge [N];
    logic [DATA_W-1:0] top_edge  [N];
    logic [DATA_W-1:0] a_in      [N][N];
    logic [DATA_W-1:0] b_in      [N][N];
    logic [DATA_W-1:0] a_q       [N][N];
    logic [DATA_W-1:0] b_q       [N][N];
    logic [DATA_W-1:0] acc_q     [N][N];
    logic [3:0]        count;
    logic              clear;
    logic              enable;

    // Restart request: reset always, plus the optional start pulse.
    always_comb begin
`ifdef SYSTOLIC_START_EN
        clear = rst_i | start_i;
`else
        clear = rst_i;
`endif
        enable = ~done;
    end

    // Gather the edge streams so the mesh can be wired with loops.
    always_comb begin
        left_edge[0] = left_i_0;
        left_edge[1] = left_i_4;
        left_edge[2] = left_i_8;
        left_edge[3] = left_i_12;
        top_edge[0]  = up_i_0;
        top_edge[1]  = up_i_1;
        top_edge[2]  = up_i_2;
        top_edge[3]  = up_i_3;
    end

    // Mesh routing: A flows rightwards along rows, B flows downwards along columns.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_in[r][c] = (c == 0) ? left_edge[r] : a_q[r][(c == 0) ? 0 : c - 1];
                b_in[r][c] = (r == 0) ? top_edge[c]  : b_q[(r == 0) ? 0 : r - 1][c];
            end
        end
    end

    genvar gr, gc;
    generate
        for (gr = 0; gr < N; gr++) begin : g_row
            for (gc = 0; gc < N; gc++) begin : g_col
                systolic_mul_4x4_pe #(
                    .DATA_W (DATA_W)
                ) u_pe (
                    .clk_i  (clk_i),
                    .clear  (clear),
                    .enable (enable),
                    .a_in   (a_in[gr][gc]),
                    .b_in   (b_in[gr][gc]),
                    .a_q    (a_q[gr][gc]),
                    .b_q    (b_q[gr][gc]),
                    .acc_q  (acc_q[gr][gc])
                );
                assign c_o[(N * gr + gc) * DATA_W +: DATA_W] = acc_q[gr][gc];
            end
        end
    endgenerate

    // Edge counter; done is sticky and freezes the whole array until the next restart.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (!done) begin
            count <= count + 4'd1;
            if (count == LAST_COUNT) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mul_4x4.sv
// tb/tb_systolic_mul_4x4.sv - scoreboard testbench for systolic_mul_4x4

module tb_systolic_mul_4x4;

    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
`ifdef SYSTOLIC_START_EN
    logic           start;
`endif
    logic [DW-1:0]  l0, l4, l8, l12, u0, u1, u2, u3;
    logic [16*DW-1:0] c_o;
    logic           done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] ma [4][4];
    logic [DW-1:0] mb [4][4];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    systolic_mul_4x4 #(.DATA_W(DW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
`ifdef SYSTOLIC_START_EN
        .start_i   (start),
`endif
        .left_i_0  (l0),
        .left_i_4  (l4),
        .left_i_8  (l8),
        .left_i_12 (l12),
        .up_i_0    (u0),
        .up_i_1    (u1),
        .up_i_2    (u2),
        .up_i_3    (u3),
        .c_o       (c_o),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive_step(input int t);
        logic [DW-1:0] lv [4];
        logic [DW-1:0] uv [4];
        for (int k = 0; k < 4; k++) begin
            lv[k] = (t >= k && t <= k + 3) ? ma[k][t - k] : '0;
            uv[k] = (t >= k && t <= k + 3) ? mb[t - k][k] : '0;
        end
        l0 = lv[0]; l4 = lv[1]; l8 = lv[2]; l12 = lv[3];
        u0 = uv[0]; u1 = uv[1]; u2 = uv[2]; u3 = uv[3];
    endtask

    task automatic drive_garbage();
        l0 = $urandom | 1; l4 = $urandom | 1; l8 = $urandom | 1; l12 = $urandom | 1;
        u0 = $urandom | 1; u1 = $urandom | 1; u2 = $urandom | 1; u3 = $urandom | 1;
    endtask

    task automatic push_expected();
        logic [DW-1:0] sum;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum = '0;
                for (int k = 0; k < 4; k++) sum = sum + ma[r][k] * mb[k][c];
                exp_q.push_back(sum);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_garbage();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge just after restart release; returns at the negedge after edge 9.
    task automatic run_stream(input string tag);
        int n;
        push_expected();
        for (int t = 0; t < 10; t++) begin
            drive_step(t);
            @(negedge clk);
            if (t == 8) check_eq({tag, "_done_early"}, DW'(done), '0);
        end
        drive_step(10);
        check_eq({tag, "_done_edge9"}, DW'(done), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [DW-1:0] e;
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() == 0) begin
                check_eq($sformatf("%s_queue_empty_%0d", tag, i), '1, '0);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("%s_c%0d", tag, i), c_o[i*DW +: DW], e);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_done"}, DW'(done), '0);
        for (int i = 0; i < 16; i++) check_eq($sformatf("%s_c%0d", tag, i), c_o[i*DW +: DW], '0);
    endtask

    task automatic load_nominal();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = DW'(4 * r + c + 1);
                mb[r][c] = DW'(c + 1);
            end
    endtask

    task automatic load_identity_b();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = DW'(4 * r + c + 1);
                mb[r][c] = (r == c) ? DW'(1) : DW'(0);
            end
    endtask

    logic [16*DW-1:0] snap;

    initial begin
        rst = 1'b1;
`ifdef SYSTOLIC_START_EN
        start = 1'b0;
`endif
        drive_garbage();
        repeat (3) @(negedge clk);
        check_cleared("reset");

        // Nominal product, plus a few hand-derived anchors
        load_nominal();
        do_reset();
        run_stream("nom");
        check_eq("nom_anchor_c0", c_o[0*DW +: DW], 32'd10);
        check_eq("nom_anchor_c7", c_o[7*DW +: DW], 32'd104);
        check_eq("nom_anchor_c15", c_o[15*DW +: DW], 32'd232);
        pop_compare("nom");

        // Freeze after done: garbage inputs must not disturb the result
        snap = c_o;
        for (int i = 0; i < 5; i++) begin
            drive_garbage();
            @(negedge clk);
            check_eq($sformatf("freeze_done_%0d", i), DW'(done), 32'd1);
            check_eq($sformatf("freeze_c0_%0d", i), c_o[0*DW +: DW], snap[0*DW +: DW]);
            check_eq($sformatf("freeze_c15_%0d", i), c_o[15*DW +: DW], snap[15*DW +: DW]);
        end

        // Identity
        load_identity_b();
        do_reset();
        run_stream("ident");
        for (int i = 0; i < 16; i++) check_eq($sformatf("ident_anchor_c%0d", i), c_o[i*DW +: DW], DW'(i + 1));
        pop_compare("ident");

        // Mid-run reset at edge 5, then rerun the nominal case
        load_nominal();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drive_step(t);
            @(negedge clk);
        end
        drive_step(5);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("midrst");
        rst = 1'b0;
        run_stream("rerun");
        pop_compare("rerun");

        // Wrap-around: 0x10000 * 0x10000 truncates to 0
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        ma[0][0] = 32'h0001_0000;
        mb[0][0] = 32'h0001_0000;
        do_reset();
        run_stream("wrap");
        check_eq("wrap_anchor_c0", c_o[0*DW +: DW], '0);
        pop_compare("wrap");

`ifdef SYSTOLIC_START_EN
        // Start pulse restarts after a completed run
        load_nominal();
        do_reset();
        run_stream("snom");
        pop_compare("snom");
        start = 1'b1;
        drive_garbage();
        @(negedge clk);
        start = 1'b0;
        check_cleared("start");
        load_identity_b();
        run_stream("sident");
        pop_compare("sident");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
